// File: rtl/datapath_pkg.sv
// Shared definitions for the issue stage and the ALU/shifter datapath it feeds:
// opcode encodings, flag bit positions and the defined-opcode test.
package datapath_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // Opcodes with the top bit set are NOPs that flow through without effect.
  function automatic logic is_defined_op(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

endpackage

// File: rtl/regfile_issue_stage_if.sv
// Decoded-instruction issue channel (valid/ready) between the decoder and the
// issue stage.
interface regfile_issue_stage_if #(
  parameter int WIDTH = 8,
  parameter int RAW   = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_opcode;
  logic [RAW-1:0]   in_rd;
  logic [RAW-1:0]   in_rs1;
  logic [RAW-1:0]   in_rs2;
  logic             in_imm_en;
  logic [WIDTH-1:0] in_imm;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
    output in_ready
  );
endinterface

// File: rtl/issue_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, R0 hardwired to zero.
module issue_regfile #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  localparam int RAW  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [RAW-1:0]   waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [RAW-1:0]   raddr1_i,
  output logic [WIDTH-1:0] rdata1_o,
  input  logic [RAW-1:0]   raddr2_i,
  output logic [WIDTH-1:0] rdata2_o
);

  logic [WIDTH-1:0] mem_q [NREGS];

  // Storage array; entry 0 is never written so it stays at its reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/regfile_issue_stage.sv
// Operand issue and writeback around the combinational ALU/shifter datapath:
// EX register drives the datapath, WB register commits to regfile and flags.
module regfile_issue_stage
  import datapath_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  localparam int RAW  = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  regfile_issue_stage_if.slave  issue,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [3:0]            alu_opcode,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_neg,
  input  logic                  alu_carry,
  input  logic                  alu_overflow,
  output logic                  wb_valid,
  output logic [RAW-1:0]        wb_rd,
  output logic [WIDTH-1:0]      wb_data,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  flag_c,
  output logic                  flag_v
);

  logic             ex_valid_q, ex_valid_d;
  logic [3:0]       ex_op_q, ex_op_d;
  logic [RAW-1:0]   ex_rd_q, ex_rd_d;
  logic [WIDTH-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
  logic             wb_valid_q, wb_valid_d;
  logic             wb_def_q, wb_def_d;
  logic [RAW-1:0]   wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic [3:0]       wb_flags_q, wb_flags_d;
  logic [3:0]       flag_q, flag_d;
  logic [3:0]       alu_flags_s;
  logic [WIDTH-1:0] rf_rd1_s, rf_rd2_s, opa_s, opb_s;
  logic             ex_fwd_ok_s, wb_fwd_ok_s, commit_s, flag_upd_s;

  issue_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (commit_s),
    .waddr_i  (wb_rd_q),
    .wdata_i  (wb_data_q),
    .raddr1_i (issue.in_rs1),
    .rdata1_o (rf_rd1_s),
    .raddr2_i (issue.in_rs2),
    .rdata2_o (rf_rd2_s)
  );

  assign issue.in_ready = !hold;

  // A stage may forward only if it will actually write a non-zero register.
  assign ex_fwd_ok_s = ex_valid_q && is_defined_op(ex_op_q) && (ex_rd_q != '0);
  assign wb_fwd_ok_s = wb_valid_q && wb_def_q && (wb_rd_q != '0);
  assign commit_s    = wb_fwd_ok_s && !hold;
  assign flag_upd_s  = wb_valid_q && wb_def_q && !hold;

  // Operand resolution: youngest producer first (EX), then WB, then regfile.
  always_comb begin
    if (ex_fwd_ok_s && (ex_rd_q == issue.in_rs1)) begin
      opa_s = alu_result;
    end else if (wb_fwd_ok_s && (wb_rd_q == issue.in_rs1)) begin
      opa_s = wb_data_q;
    end else begin
      opa_s = rf_rd1_s;
    end
    if (issue.in_imm_en) begin
      opb_s = issue.in_imm;
    end else if (ex_fwd_ok_s && (ex_rd_q == issue.in_rs2)) begin
      opb_s = alu_result;
    end else if (wb_fwd_ok_s && (wb_rd_q == issue.in_rs2)) begin
      opb_s = wb_data_q;
    end else begin
      opb_s = rf_rd2_s;
    end
  end

  // Pack datapath flags into the architectural bit order.
  always_comb begin
    alu_flags_s         = 4'b0000;
    alu_flags_s[FLAG_Z] = alu_zero;
    alu_flags_s[FLAG_N] = alu_neg;
    alu_flags_s[FLAG_C] = alu_carry;
    alu_flags_s[FLAG_V] = alu_overflow;
  end

  // Pipeline advance; hold freezes both stages together.
  always_comb begin
    if (!hold) begin
      ex_valid_d = issue.in_valid;
      ex_op_d    = issue.in_opcode;
      ex_rd_d    = issue.in_rd;
      ex_a_d     = opa_s;
      ex_b_d     = opb_s;
      wb_valid_d = ex_valid_q;
      wb_def_d   = is_defined_op(ex_op_q);
      wb_rd_d    = ex_rd_q;
      wb_data_d  = alu_result;
      wb_flags_d = alu_flags_s;
    end else begin
      ex_valid_d = ex_valid_q;
      ex_op_d    = ex_op_q;
      ex_rd_d    = ex_rd_q;
      ex_a_d     = ex_a_q;
      ex_b_d     = ex_b_q;
      wb_valid_d = wb_valid_q;
      wb_def_d   = wb_def_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      wb_flags_d = wb_flags_q;
    end
  end

  // Flags become visible in the commit cycle and are then retained.
  always_comb begin
    if (flag_upd_s) begin
      flag_d = wb_flags_q;
    end else begin
      flag_d = flag_q;
    end
  end

  // EX, WB and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= 4'b0000;
      ex_rd_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_def_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_flags_q <= 4'b0000;
      flag_q     <= 4'b0000;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_rd_q    <= ex_rd_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      wb_valid_q <= wb_valid_d;
      wb_def_q   <= wb_def_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_flags_q <= wb_flags_d;
      flag_q     <= flag_d;
    end
  end

  assign alu_a      = ex_a_q;
  assign alu_b      = ex_b_q;
  assign alu_opcode = ex_op_q;
  assign wb_valid   = commit_s;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign flag_z     = flag_d[FLAG_Z];
  assign flag_n     = flag_d[FLAG_N];
  assign flag_c     = flag_d[FLAG_C];
  assign flag_v     = flag_d[FLAG_V];

endmodule

// File: tb/tb_regfile_issue_stage.sv
// Directed + random bench for regfile_issue_stage with an in-order
// architectural reference model and a behavioural datapath.
module tb_regfile_issue_stage;
  import datapath_pkg::*;

  logic       clk, rst_n, hold;
  logic [7:0] alu_a, alu_b, alu_result, wb_data;
  logic [3:0] alu_opcode;
  logic       alu_zero, alu_neg, alu_carry, alu_overflow;
  logic       wb_valid, flag_z, flag_n, flag_c, flag_v;
  logic [2:0] wb_rd;
  logic [11:0] dp_s;

  regfile_issue_stage_if #(.WIDTH(8), .RAW(3)) issue_if ();

  regfile_issue_stage #(.WIDTH(8), .NREGS(8)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .issue(issue_if),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU/shifter: returns {V,C,N,Z,result}.
  function automatic logic [11:0] dp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [7:0] r;
    logic [8:0] t;
    logic c, v;
    r = 8'h00; t = 9'h000; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
      OP_SUB: begin t = {1'b0, a} - {1'b0, b}; r = t[7:0]; c = t[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SLL: r = a << b[2:0];
      OP_SRL: r = a >> b[2:0];
      default: r = 8'h00;
    endcase
    return {v, c, r[7], (r == 8'h00), r};
  endfunction

  always_comb begin
    dp_s         = dp(alu_a, alu_b, alu_opcode);
    alu_result   = dp_s[7:0];
    alu_zero     = dp_s[8];
    alu_neg      = dp_s[9];
    alu_carry    = dp_s[10];
    alu_overflow = dp_s[11];
  end

  typedef struct packed {
    logic       v;
    logic       commit;
    logic       fupd;
    logic [2:0] rd;
    logic [7:0] data;
    logic [3:0] fl;
  } exp_t;

  exp_t       pipe[$];
  logic [7:0] spec_rf [8];
  logic [3:0] ref_fl;
  logic [7:0] last_data;
  logic [2:0] last_rd;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    pipe.delete();
    for (int i = 0; i < 8; i++) spec_rf[i] = 8'h00;
    ref_fl = 4'h0;
  endtask

  // One clock: drive, check at negedge, advance the model at posedge.
  task automatic cycle(input logic v, input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic ie,
                       input logic [7:0] imm, input logic h);
    exp_t w, e;
    logic exp_wv;
    logic [3:0] exp_fl;
    logic [7:0] a, b;
    logic [11:0] res;
    issue_if.in_valid = v; issue_if.in_opcode = op; issue_if.in_rd = rd;
    issue_if.in_rs1 = rs1; issue_if.in_rs2 = rs2; issue_if.in_imm_en = ie;
    issue_if.in_imm = imm; hold = h;
    @(negedge clk);
    w = (pipe.size() == 2) ? pipe[0] : '0;
    exp_wv = w.v && w.commit && !h;
    chk("in_ready", 32'(issue_if.in_ready), 32'(!h));
    chk("wb_valid", 32'(wb_valid), 32'(exp_wv));
    if (exp_wv) begin
      chk("wb_rd", 32'(wb_rd), 32'(w.rd));
      chk("wb_data", 32'(wb_data), 32'(w.data));
      last_rd = wb_rd; last_data = wb_data;
    end
    exp_fl = (!h && w.v && w.fupd) ? w.fl : ref_fl;
    chk("flags", 32'({flag_v, flag_c, flag_n, flag_z}), 32'(exp_fl));
    @(posedge clk);
    if (!h) begin
      e = '0;
      e.v = v;
      if (v) begin
        a = spec_rf[rs1];
        b = ie ? imm : spec_rf[rs2];
        res = dp(a, b, op);
        e.fupd = !op[3];
        e.commit = !op[3] && (rd != 3'd0);
        e.rd = rd; e.data = res[7:0]; e.fl = res[11:8];
        if (e.commit) spec_rf[rd] = e.data;
      end
      pipe.push_back(e);
      if (pipe.size() > 2) begin
        w = pipe.pop_front();
        if (w.v && w.fupd) ref_fl = w.fl;
      end
    end
    #1;
  endtask

  task automatic bubble();
    cycle(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    issue_if.in_valid = 1'b1; issue_if.in_opcode = OP_ADD; issue_if.in_rd = 3'd1;
    issue_if.in_rs1 = 3'd0; issue_if.in_rs2 = 3'd0; issue_if.in_imm_en = 1'b1;
    issue_if.in_imm = 8'h55;
    last_rd = 3'd0; last_data = 8'h00;
    model_clear();
    #1;
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    chk("rst_alu_b", 32'(alu_b), 32'h0);
    chk("rst_alu_op", 32'(alu_opcode), 32'h0);
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_wb_rd", 32'(wb_rd), 32'h0);
    chk("rst_wb_data", 32'(wb_data), 32'h0);
    chk("rst_flags", 32'({flag_v, flag_c, flag_n, flag_z}), 32'h0);
    chk("rst_in_ready", 32'(issue_if.in_ready), 32'h1);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ignores_hs", 32'(alu_a | alu_b), 32'h0);
    rst_n = 1'b1;

    // ADD r1 = r0 + 5
    cycle(1'b1, OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05, 1'b0);
    bubble(); bubble();
    chk("plan_add5", 32'({last_rd, last_data}), 32'({3'd1, 8'h05}));
    chk("plan_add5_fl", 32'({flag_v, flag_c, flag_n, flag_z}), 32'h0);

    // EX forward: r1 = 7F; r2 = r1 + 1
    cycle(1'b1, OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h7F, 1'b0);
    cycle(1'b1, OP_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 8'h01, 1'b0);
    bubble(); bubble();
    chk("plan_exfwd", 32'({last_rd, last_data}), 32'({3'd2, 8'h80}));
    chk("plan_exfwd_fl", 32'({flag_v, flag_c, flag_n, flag_z}), 32'b1010);

    // WB forward across a NOP bubble
    cycle(1'b1, OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 8'h03, 1'b0);
    cycle(1'b1, 4'b1010, 3'd4, 3'd0, 3'd0, 1'b1, 8'hAA, 1'b0);
    cycle(1'b1, OP_SLL, 3'd2, 3'd1, 3'd0, 1'b1, 8'h02, 1'b0);
    bubble(); bubble();
    chk("plan_wbfwd", 32'({last_rd, last_data}), 32'({3'd2, 8'h0C}));

    // R0 write suppressed
    cycle(1'b1, OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 8'h09, 1'b0);
    cycle(1'b1, OP_ADD, 3'd3, 3'd0, 3'd0, 1'b1, 8'h00, 1'b0);
    bubble(); bubble();
    chk("plan_r0", 32'({last_rd, last_data}), 32'({3'd3, 8'h00}));
    chk("plan_r0_fl", 32'({flag_v, flag_c, flag_n, flag_z}), 32'b0001);

    // Hold with both stages full
    cycle(1'b1, OP_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 8'h11, 1'b0);
    cycle(1'b1, OP_ADD, 3'd5, 3'd4, 3'd0, 1'b1, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, OP_XOR, 3'd6, 3'd5, 3'd4, 1'b0, 8'h00, 1'b1);
    bubble(); bubble();
    chk("plan_hold", 32'({last_rd, last_data}), 32'({3'd5, 8'h33}));

    // NOP leaves Z set, then reset with two in flight
    cycle(1'b1, OP_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 8'h00, 1'b0);
    cycle(1'b1, 4'b1111, 3'd7, 3'd5, 3'd5, 1'b0, 8'h00, 1'b0);
    bubble(); bubble(); bubble();
    chk("plan_nop_fl", 32'({flag_v, flag_c, flag_n, flag_z}), 32'b0001);
    cycle(1'b1, OP_ADD, 3'd1, 3'd5, 3'd0, 1'b1, 8'h01, 1'b0);
    cycle(1'b1, OP_ADD, 3'd2, 3'd5, 3'd0, 1'b1, 8'h02, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_wb_valid", 32'(wb_valid), 32'h0);
    chk("midrst_flags", 32'({flag_v, flag_c, flag_n, flag_z}), 32'h0);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k < 8; k++) cycle(1'b1, OP_ADD, 3'(k), 3'(k), 3'd0, 1'b1, 8'h00, 1'b0);
    bubble(); bubble();
    chk("plan_rst_r7", 32'({last_rd, last_data}), 32'({3'd7, 8'h00}));

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 9) != 0), 4'($urandom_range(0, 11)), 3'($urandom),
            3'($urandom), 3'($urandom), 1'($urandom_range(0, 2) == 0), 8'($urandom),
            1'($urandom_range(0, 9) == 0));
    end
    bubble(); bubble();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_issue_stage.md
Name: regfile_issue_stage

Overview:
- Upstream operand-issue and writeback wrapper around the existing combinational ALU/shifter datapath.
- Accepts decoded instructions on a valid/ready interface and reads operands from an internal register file, with forwarding.
- Drives A/B/OpCode to the datapath from an EX pipeline register, then captures Result and flags into a WB register.
- Commits WB to the register file and to an architectural flag register. Two-stage pipeline: EX, then WB.

Parameters:
- WIDTH, 8, data width; must match the datapath instance (8/16/32).
- NREGS, 8, number of architectural registers; power of two, at least 2. Local RAW = $clog2(NREGS).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hold  in  1  global stall; freezes both pipeline stages.
- in_valid  in  1  instruction offered.
- in_ready  out  1  = !hold.
- in_opcode  in  4  datapath opcode: 0000–0111 defined; 1000–1111 is a NOP.
- in_rd  in  RAW  destination register.
- in_rs1  in  RAW  source register for A.
- in_rs2  in  RAW  source register for B.
- in_imm_en  in  1  when 1, B = in_imm instead of rs2.
- in_imm  in  WIDTH  immediate value.
- alu_a  out  WIDTH  to datapath A.
- alu_b  out  WIDTH  to datapath B.
- alu_opcode  out  4  to datapath OpCode.
- alu_result  in  WIDTH  from datapath Result.
- alu_zero, alu_neg, alu_carry, alu_overflow  in  1 each  datapath flags.
- wb_valid  out  1  commit strobe.
- wb_rd  out  RAW  committed destination.
- wb_data  out  WIDTH  committed value.
- flag_z, flag_n, flag_c, flag_v  out  1 each  architectural flags.

Behaviour:
- Reset: asynchronous, active-low. Clears EX/WB valids, all pipeline registers, every register-file entry, and all flags. All outputs read 0 during and after reset except in_ready, which follows !hold. Handshakes while rst_n=0 are ignored.
- Reset mid-operation flushes all in-flight instructions. Nothing commits, and wb_valid drops immediately.
- Accept condition: in_valid && in_ready.
- Cycle N (accept): operands resolved combinationally and captured into the EX register at the end of N.
- Cycle N+1: EX drives alu_*; datapath outputs are captured into the WB register at the end of N+1.
- Cycle N+2: wb_valid=1 when the instruction is defined and rd≠0 and !hold. The register file is written at the end of N+2. Flags show the instruction's values from N+2 onward.
- Throughput: one instruction per cycle.
- Operand forwarding per source: EX-stage match, then WB-stage match, then register file. A match requires the stage to be valid, defined, and rd≠0.
  - EX match forwards alu_result combinationally.
  - WB match forwards wb_data.
- R0 always reads 0. Writes to R0 and forwarding from R0 are suppressed.
- Register file write is synchronous. The write-through case is covered by WB forwarding.
- NOP opcodes (1000–1111):
  - flow through the pipeline;
  - wb_valid stays 0;
  - no register write;
  - flags unchanged.
- Flag update rule: all four flags are copied for every defined opcode. C/V are 0 for non-ADD/SUB ops, as the datapath produces them.
- hold=1:
  - EX and WB registers, the register file, and flags keep their values;
  - wb_valid is forced to 0;
  - the pending commit takes place on the first cycle with hold=0.
- in_valid=0: a bubble (valid=0) enters EX.
- Width rule: in_imm and all registers are WIDTH bits with no extension.

Decomposition:
- Shared package datapath_pkg holds:
  - opcode localparams: OP_ADD=0000 … OP_SRL=0111;
  - the function is_defined_op(op) = (op[3]==0);
  - the flag bit-index constants.
- One sub-module, issue_regfile: NREGS×WIDTH, two asynchronous read ports, one synchronous write port, R0 hardwired to zero, asynchronous reset clears all entries.
- The datapath is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then ADD r1 = r0 + imm 0x05 → wb_valid at N+2 with wb_rd=1, wb_data=0x05; flags Z=0, N=0, C=0, V=0.
- Back-to-back dependence: ADD r1 = r0 + imm 0x7F, then ADD r2 = r1 + imm 0x01 (EX forward) → r2 = 0x80 with N=1, V=1, C=0, Z=0.
- Distance-2 dependence: r1 = 0x03, then an opcode 1010 bubble, then SLL r2 = r1 << imm 0x02 (WB forward) → r2 = 0x0C.
- Write to R0: ADD r0 = imm 0x09 → wb_valid=0, no write; next ADD r3 = r0 + imm 0 → 0x00, Z=1.
- hold asserted for 3 cycles while EX and WB are both full → in_ready=0 and wb_valid=0 throughout, no state change. After release, commits follow in order with the same values.
- NOP 1111 while flags = {Z=1} → flags unchanged, no commit. Then assert rst_n=0 with two instructions in flight → wb_valid=0 at once, r1..r7 read 0 afterward.
